// File: rtl/subservient_dbg_arb.sv
// Debug/CPU arbiter for the byte-wide SRAM: debug Wishbone 32-bit accesses become four byte cycles.
// Optional macro SUBSERVIENT_DBG_READ_EN adds debug reads; without it debug reads ack at once with zero data.
//
// state  | meaning
// IDLE   | CPU passthrough when not debug-owned; wait for debug strobe
// WR     | write byte lane `lane` of the debug word
// RD     | issue read of byte lane `lane`, capture previous lane's data
// RDLAST | capture byte lane 3 returned by the SRAM
// ACK    | one-cycle debug acknowledge
module subservient_dbg_arb #(
   parameter int memsize = 8192,
   parameter int aw      = $clog2(memsize)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_debug_mode,
   input  logic [31:0]   i_wb_dbg_adr,
   input  logic [31:0]   i_wb_dbg_dat,
   input  logic [3:0]    i_wb_dbg_sel,
   input  logic          i_wb_dbg_we,
   input  logic          i_wb_dbg_stb,
   output logic [31:0]   o_wb_dbg_rdt,
   output logic          o_wb_dbg_ack,
   input  logic [aw-1:0] i_cpu_waddr,
   input  logic [7:0]    i_cpu_wdata,
   input  logic          i_cpu_wen,
   input  logic [aw-1:0] i_cpu_raddr,
   input  logic          i_cpu_ren,
   output logic [7:0]    o_cpu_rdata,
   output logic [aw-1:0] o_sram_waddr,
   output logic [7:0]    o_sram_wdata,
   output logic          o_sram_wen,
   output logic [aw-1:0] o_sram_raddr,
   output logic          o_sram_ren,
   input  logic [7:0]    i_sram_rdata
);

`ifdef SUBSERVIENT_DBG_READ_EN
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDLAST, S_ACK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WR, S_ACK} state_t;
`endif

   state_t          state, state_nxt;
   logic [1:0]      lane, lane_nxt;
   logic            dbg_own;
   logic [aw-3:0]   word;
   logic            unused_adr;

   assign word        = i_wb_dbg_adr[aw-1:2];
   assign unused_adr  = &{1'b0, i_wb_dbg_adr[31:aw], i_wb_dbg_adr[1:0]};
   assign o_cpu_rdata = i_sram_rdata;

   // Ownership is only re-evaluated between transactions so a debug access always completes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_IDLE;
         lane    <= 2'd0;
         dbg_own <= 1'b1;
      end else begin
         state <= state_nxt;
         lane  <= lane_nxt;
         if (state == S_IDLE)
            dbg_own <= i_debug_mode;
      end
   end

   always_comb begin
      state_nxt    = state;
      lane_nxt     = lane;
      o_wb_dbg_ack = 1'b0;
      o_sram_waddr = i_cpu_waddr;
      o_sram_wdata = i_cpu_wdata;
      o_sram_wen   = i_cpu_wen & ~dbg_own;
      o_sram_raddr = i_cpu_raddr;
      o_sram_ren   = i_cpu_ren & ~dbg_own;
      case (state)
         S_IDLE: begin
            if (dbg_own && i_wb_dbg_stb) begin
               lane_nxt = 2'd0;
`ifdef SUBSERVIENT_DBG_READ_EN
               state_nxt = i_wb_dbg_we ? S_WR : S_RD;
`else
               state_nxt = i_wb_dbg_we ? S_WR : S_ACK;
`endif
            end
         end
         S_WR: begin
            o_sram_waddr = {word, lane};
            o_sram_wdata = i_wb_dbg_dat[{lane, 3'b000} +: 8];
            o_sram_wen   = i_wb_dbg_sel[lane];
            lane_nxt     = lane + 2'd1;
            if (lane == 2'd3)
               state_nxt = S_ACK;
         end
`ifdef SUBSERVIENT_DBG_READ_EN
         S_RD: begin
            o_sram_raddr = {word, lane};
            o_sram_ren   = 1'b1;
            lane_nxt     = lane + 2'd1;
            if (lane == 2'd3)
               state_nxt = S_RDLAST;
         end
         S_RDLAST: state_nxt = S_ACK;
`endif
         S_ACK: begin
            o_wb_dbg_ack = 1'b1;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef SUBSERVIENT_DBG_READ_EN
   logic [31:0] rdt;
   logic [1:0]  lane_m1;

   assign lane_m1 = lane - 2'd1;

   // SRAM data lags the address by one cycle, so each RD cycle stores the previous lane.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         rdt <= 32'd0;
      else if (state == S_RD && lane != 2'd0)
         rdt[{lane_m1, 3'b000} +: 8] <= i_sram_rdata;
      else if (state == S_RDLAST)
         rdt[31:24] <= i_sram_rdata;
   end

   assign o_wb_dbg_rdt = rdt;
`else
   assign o_wb_dbg_rdt = 32'd0;
`endif

endmodule

// File: tb/tb_subservient_dbg_arb.sv
// Scoreboard bench for subservient_dbg_arb: stimulus pushes expected SRAM/ack events, a negedge monitor pops them.
module tb_subservient_dbg_arb;
   localparam int MEMSIZE = 8192;
   localparam int AW      = 13;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          debug_mode;
   logic [31:0]   dbg_adr, dbg_dat;
   logic [3:0]    dbg_sel;
   logic          dbg_we, dbg_stb;
   logic [31:0]   dbg_rdt;
   logic          dbg_ack;
   logic [AW-1:0] cpu_waddr, cpu_raddr;
   logic [7:0]    cpu_wdata, cpu_rdata;
   logic          cpu_wen, cpu_ren;
   logic [AW-1:0] sram_waddr, sram_raddr;
   logic [7:0]    sram_wdata;
   logic          sram_wen, sram_ren;
   logic [7:0]    sram_rdata;

   subservient_dbg_arb dut (
      .i_clk(clk), .i_rst(rst), .i_debug_mode(debug_mode),
      .i_wb_dbg_adr(dbg_adr), .i_wb_dbg_dat(dbg_dat), .i_wb_dbg_sel(dbg_sel),
      .i_wb_dbg_we(dbg_we), .i_wb_dbg_stb(dbg_stb),
      .o_wb_dbg_rdt(dbg_rdt), .o_wb_dbg_ack(dbg_ack),
      .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
      .i_cpu_raddr(cpu_raddr), .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
      .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
      .o_sram_raddr(sram_raddr), .o_sram_ren(sram_ren), .i_sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct { int cyc; int addr; int data; } wexp_t;
   typedef struct { int cyc; int addr; } rexp_t;
   typedef struct { int cyc; bit chk; logic [31:0] rdt; } aexp_t;
   wexp_t wq[$];
   rexp_t rq[$];
   aexp_t aq[$];

   logic [7:0] ref_mem [MEMSIZE];
   logic [7:0] sram [MEMSIZE];
   logic       mem_init = 1'b1;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) ^ (i >> 5));
   endfunction

   // SRAM model: registered read, one-cycle latency
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEMSIZE; i++) sram[i] <= init_byte(i);
      end else begin
         if (sram_wen === 1'b1) sram[sram_waddr] <= sram_wdata;
         if (sram_ren === 1'b1) sram_rdata <= sram[sram_raddr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event seen at cycle %0d, required none", name, cyc);
   endtask

   wexp_t mw;
   rexp_t mr;
   aexp_t ma;
   always @(negedge clk) begin
      if (sram_wen === 1'b1) begin
         if (wq.size() == 0) unexpected("sram_write");
         else begin
            mw = wq.pop_front();
            check("wr_cycle", 32'(cyc), 32'(mw.cyc));
            check("wr_addr", 32'(sram_waddr), 32'(mw.addr));
            check("wr_data", 32'(sram_wdata), 32'(mw.data));
         end
      end
      if (sram_ren === 1'b1) begin
         if (rq.size() == 0) unexpected("sram_read");
         else begin
            mr = rq.pop_front();
            check("rd_cycle", 32'(cyc), 32'(mr.cyc));
            check("rd_addr", 32'(sram_raddr), 32'(mr.addr));
         end
      end
      if (dbg_ack === 1'b1) begin
         if (aq.size() == 0) unexpected("dbg_ack");
         else begin
            ma = aq.pop_front();
            check("ack_cycle", 32'(cyc), 32'(ma.cyc));
            if (ma.chk) check("ack_rdt", dbg_rdt, ma.rdt);
         end
      end
   end

   // Debug transaction; stb_drop / dm_drop give the cycle offset after sampling at which to lower those inputs.
   task automatic dbg_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int stb_drop, input int dm_drop);
      int n, base, lat;
      logic [31:0] exp_rdt;
      bit got;
      wexp_t w;
      rexp_t r;
      aexp_t a;
      n    = cyc + 1;
      base = int'((adr / 4) % (MEMSIZE / 4)) * 4;
      dbg_we = we; dbg_adr = adr; dbg_dat = dat; dbg_sel = sel; dbg_stb = 1'b1;
      exp_rdt = 32'd0;
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
               w.cyc = n + k; w.addr = base + k; w.data = int'(dat[8*k +: 8]);
               wq.push_back(w);
               ref_mem[base + k] = dat[8*k +: 8];
            end
         end
         lat = 5;
      end else begin
`ifdef SUBSERVIENT_DBG_READ_EN
         for (int k = 0; k < 4; k++) begin
            r.cyc = n + k; r.addr = base + k;
            rq.push_back(r);
            exp_rdt[8*k +: 8] = ref_mem[base + k];
         end
         lat = 6;
`else
         lat = 1;
`endif
      end
      a.cyc = n + lat - 1; a.chk = !we; a.rdt = exp_rdt;
      aq.push_back(a);
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
         @(posedge clk); #1;
         if (t == stb_drop) dbg_stb = 1'b0;
         if (t == dm_drop) debug_mode = 1'b0;
         if (dbg_ack === 1'b1) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL ack_timeout: no ack within 12 cycles of cycle %0d, required ack", n);
      end
      @(posedge clk); #1;
      dbg_stb = 1'b0;
   endtask

   task automatic cpu_op(input logic wen, input logic [AW-1:0] waddr, input logic [7:0] wdata,
                         input logic ren, input logic [AW-1:0] raddr);
      logic [7:0] exp_rd;
      wexp_t w;
      rexp_t r;
      cpu_wen = wen; cpu_waddr = waddr; cpu_wdata = wdata;
      cpu_ren = ren; cpu_raddr = raddr;
      exp_rd = ref_mem[raddr];
      if (wen) begin
         w.cyc = cyc; w.addr = int'(waddr); w.data = int'(wdata);
         wq.push_back(w);
         ref_mem[waddr] = wdata;
      end
      if (ren) begin
         r.cyc = cyc; r.addr = int'(raddr);
         rq.push_back(r);
      end
      @(posedge clk); #1;
      cpu_wen = 1'b0; cpu_ren = 1'b0;
      if (ren) check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base, stb_drop;
      logic [AW-1:0] last_waddr;
      wexp_t w;
      for (int i = 0; i < MEMSIZE; i++) ref_mem[i] = init_byte(i);
      debug_mode = 1'b1;
      dbg_adr = 32'd0; dbg_dat = 32'd0; dbg_sel = 4'h0; dbg_we = 1'b0; dbg_stb = 1'b0;
      cpu_waddr = '0; cpu_raddr = '0; cpu_wdata = 8'h00;
      cpu_wen = 1'b1; cpu_ren = 1'b1;
      rst = 1'b1;
      last_waddr = '0;
      repeat (3) @(posedge clk);
      #1;
      mem_init = 1'b0;
      check("rst_ack", 32'(dbg_ack), 32'd0);
      check("rst_rdt", dbg_rdt, 32'd0);
      check("rst_wen", 32'(sram_wen), 32'd0);
      check("rst_ren", 32'(sram_ren), 32'd0);
      cpu_wen = 1'b0; cpu_ren = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      dbg_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, -1);
      dbg_txn(1'b1, 32'h20, 32'h11223344, 4'b0101, -1, -1);
      dbg_txn(1'b0, 32'h10, 32'h0, 4'hF, -1, -1);
      dbg_txn(1'b1, 32'h30, 32'hCAFEF00D, 4'b0000, -1, -1);
      dbg_txn(1'b1, 32'h2004, 32'h0BADC0DE, 4'hF, -1, -1);
      dbg_txn(1'b0, 32'h4, 32'h0, 4'hF, -1, -1);
      dbg_txn(1'b1, 32'h40, 32'h5566_7788, 4'hF, 2, -1);
      dbg_txn(1'b0, 32'h40, 32'h0, 4'hF, 1, -1);

      // CPU requests stay asserted while debug owns the SRAM and must never reach it
      for (int i = 0; i < 24; i++) begin
         cpu_wen = 1'b1; cpu_ren = 1'($urandom);
         cpu_waddr = AW'($urandom); cpu_raddr = AW'($urandom); cpu_wdata = 8'($urandom);
         stb_drop = int'($urandom_range(0, 5)) - 1;
         dbg_txn(1'($urandom), $urandom, $urandom, 4'($urandom), stb_drop, -1);
      end
      cpu_wen = 1'b0; cpu_ren = 1'b0;

      dbg_txn(1'b0, 32'h10, 32'h0, 4'hF, -1, -1);
      // reset during lane 2 of a write: lanes 0 and 1 only
      n = cyc + 1;
      base = 32'h50;
      dbg_we = 1'b1; dbg_adr = 32'h50; dbg_dat = 32'hA1B2C3D4; dbg_sel = 4'hF; dbg_stb = 1'b1;
      for (int k = 0; k < 2; k++) begin
         w.cyc = n + k; w.addr = base + k; w.data = int'(dbg_dat[8*k +: 8]);
         wq.push_back(w);
         ref_mem[base + k] = dbg_dat[8*k +: 8];
      end
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1; dbg_stb = 1'b0;
      #1;
      check("midrst_wen", 32'(sram_wen), 32'd0);
      check("midrst_ack", 32'(dbg_ack), 32'd0);
      check("midrst_rdt", dbg_rdt, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      dbg_txn(1'b0, 32'h50, 32'h0, 4'hF, -1, -1);

      // debug_mode falls in WR lane 1: write completes, then CPU gets the SRAM
      dbg_txn(1'b1, 32'h60, 32'h99AABBCC, 4'hF, -1, 1);
      @(posedge clk); #1;
      cpu_op(1'b1, 13'h61, 8'h77, 1'b0, '0);

      // CPU ownership: strobe held high is ignored
      dbg_we = 1'b1; dbg_adr = 32'h70; dbg_dat = 32'h12345678; dbg_sel = 4'hF; dbg_stb = 1'b1;
      cpu_op(1'b1, 13'd5, 8'hA5, 1'b0, '0);
      cpu_op(1'b0, '0, 8'h00, 1'b1, 13'd5);
      for (int i = 0; i < 16; i++) begin
         last_waddr = AW'($urandom);
         cpu_op(1'($urandom), last_waddr, 8'($urandom), 1'($urandom), AW'($urandom));
      end
      cpu_op(1'b1, last_waddr, 8'h3C, 1'b1, last_waddr);
      dbg_stb = 1'b0;
      debug_mode = 1'b1;
      @(posedge clk); #1;

      dbg_txn(1'b0, 32'h4, 32'h0, 4'hF, -1, -1);
      dbg_txn(1'b0, 32'h60, 32'h0, 4'hF, -1, -1);
      dbg_txn(1'b0, 32'(last_waddr), 32'h0, 4'hF, -1, -1);

      repeat (4) @(posedge clk);
      #1;
      check("wq_left", 32'(wq.size()), 32'd0);
      check("rq_left", 32'(rq.size()), 32'd0);
      check("aq_left", 32'(aq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
